xbar_bridge_rr_arbiter: RTL and testbench

- N-channel request arbiter with a rotating round-robin pointer. It shares one bridge/L2 target port between N_CH TCDM-style masters.
- Tracks outstanding transactions in an in-order route FIFO and steers each response back to the channel that issued it.
- Sits in the XBAR_BRIDGE path ahead of the target port. It generalises the existing 2-way request mux to N channels and adds response routing and an outstanding-transaction limit.

---
 rtl/xbar_bridge_pkg.sv | 34 +++
 rtl/xbar_bridge_route_fifo.sv | 61 ++++++
 rtl/xbar_bridge_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_xbar_bridge_rr_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_bridge_pkg.sv
// Shared types and the round-robin pick function for the XBAR bridge arbiter.
// ch_idx_t is sized for the largest supported channel count. Users truncate it
// to their own CH_W.
package xbar_bridge_pkg;

  localparam int MAX_CH   = 64;
  localparam int MAX_CH_W = 6;

  typedef logic [MAX_CH_W-1:0] ch_idx_t;
  typedef logic [MAX_CH_W:0]   ch_cnt_t;

  // Scan ptr, ptr+1, ... mod n and return the first requesting channel.
  // When nothing requests, found=0 and ptr is returned so that payload
  // muxing has a well-defined select.
  function automatic ch_idx_t rr_pick(input logic [MAX_CH-1:0] req,
                                      input ch_idx_t           ptr,
                                      input ch_cnt_t           n,
                                      output logic             found);
    ch_cnt_t s;
    ch_idx_t win;
    found = 1'b0;
    win   = ptr;
    for (int k = 0; k < MAX_CH; k++) begin
      s = {1'b0, ptr} + ch_cnt_t'(k);
      if (s >= n) s = s - n;
      if ((k < int'(n)) && !found && req[s[MAX_CH_W-1:0]]) begin
        found = 1'b1;
        win   = s[MAX_CH_W-1:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/xbar_bridge_route_fifo.sv
// In-order route FIFO. It holds the channel index of each outstanding
// transaction so that responses can be steered back to their issuer. The depth
// does not need to be a power of two.
module xbar_bridge_route_fifo
  import xbar_bridge_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage is data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xbar_bridge_rr_arbiter.sv
// N-channel round-robin request arbiter in front of one bridge/L2 target port.
// Issued channel indices are queued in order, and each response is routed back
// with zero added latency. The outstanding limit is taken from the registered
// count only, so data_r_valid_i has no combinational path to data_req_o.
module xbar_bridge_rr_arbiter
  import xbar_bridge_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int BE_WIDTH   = DATA_WIDTH / 8,
  parameter  int ID_WIDTH   = 20,
  parameter  int AUX_WIDTH  = 6,
  parameter  int MAX_OUTST  = 4,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W      = $clog2(MAX_OUTST + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            data_req_i,
  input  logic [N_CH*ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_CH-1:0]            data_wen_i,
  input  logic [N_CH*DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_CH*BE_WIDTH-1:0]   data_be_i,
  input  logic [N_CH*ID_WIDTH-1:0]   data_ID_i,
  input  logic [N_CH*AUX_WIDTH-1:0]  data_aux_i,
  output logic [N_CH-1:0]            data_gnt_o,
  output logic                       data_req_o,
  output logic [ADDR_WIDTH-1:0]      data_add_o,
  output logic                       data_wen_o,
  output logic [DATA_WIDTH-1:0]      data_wdata_o,
  output logic [BE_WIDTH-1:0]        data_be_o,
  output logic [ID_WIDTH-1:0]        data_ID_o,
  output logic [AUX_WIDTH-1:0]       data_aux_o,
  input  logic                       data_gnt_i,
  input  logic                       data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]      data_r_rdata_i,
  output logic [N_CH-1:0]            data_r_valid_o,
  output logic [DATA_WIDTH-1:0]      data_r_rdata_o,
  output logic [CNT_W-1:0]           outst_cnt_o,
  output logic                       resp_err_o
);

  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       winner;
  logic [CH_W-1:0]       head;
  ch_idx_t               pick_idx;
  logic                  found;
  logic                  full;
  logic                  empty;
  logic                  hs;
  logic                  pop;

  logic [ADDR_WIDTH-1:0] add_arr   [N_CH];
  logic [DATA_WIDTH-1:0] wdata_arr [N_CH];
  logic [BE_WIDTH-1:0]   be_arr    [N_CH];
  logic [ID_WIDTH-1:0]   id_arr    [N_CH];
  logic [AUX_WIDTH-1:0]  aux_arr   [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign add_arr[c]   = data_add_i[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[c] = data_wdata_i[c*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[c]    = data_be_i[c*BE_WIDTH +: BE_WIDTH];
    assign id_arr[c]    = data_ID_i[c*ID_WIDTH +: ID_WIDTH];
    assign aux_arr[c]   = data_aux_i[c*AUX_WIDTH +: AUX_WIDTH];
  end

  // Round-robin scan starting at rr_ptr. With no requests the select falls back to rr_ptr.
  always_comb begin
    pick_idx = rr_pick(MAX_CH'(data_req_i), ch_idx_t'(rr_ptr), ch_cnt_t'(N_CH), found);
  end

  assign winner     = CH_W'(pick_idx);
  assign data_req_o = (|data_req_i) & ~full;
  assign hs         = data_req_o & data_gnt_i;

  // Only the winner can see a grant, and only when the queue has room.
  always_comb begin
    data_gnt_o = '0;
    if (hs) data_gnt_o[winner] = 1'b1;
  end

  // Payload of the selected channel is forwarded without being latched.
  always_comb begin
    data_add_o   = add_arr[winner];
    data_wen_o   = data_wen_i[winner];
    data_wdata_o = wdata_arr[winner];
    data_be_o    = be_arr[winner];
    data_ID_o    = id_arr[winner];
    data_aux_o   = aux_arr[winner];
  end

  // The pointer moves one past the channel just served and holds when there is no handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (winner == CH_W'(N_CH - 1)) ? '0 : winner + CH_W'(1);
    end
  end

  xbar_bridge_route_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (CH_W)
  ) u_route_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (hs),
    .din   (winner),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outst_cnt_o)
  );

  assign pop            = data_r_valid_i & ~empty;
  assign resp_err_o     = data_r_valid_i & empty;
  assign data_r_rdata_o = data_r_rdata_i;

  // Steer a response to the channel at the head of the route queue in the same cycle.
  always_comb begin
    data_r_valid_o = '0;
    if (pop) data_r_valid_o[head] = 1'b1;
  end

endmodule

// File: tb/tb_xbar_bridge_rr_arbiter.sv
// Directed bench for xbar_bridge_rr_arbiter (4 channels, 4 outstanding).
module tb_xbar_bridge_rr_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int IW = 20;
  localparam int XW = 6;
  localparam int MO = 4;
  localparam int CW = 3;

  logic            clk;
  logic            rst_n;
  logic [NC-1:0]   data_req_i;
  logic [NC*AW-1:0] data_add_i;
  logic [NC-1:0]   data_wen_i;
  logic [NC*DW-1:0] data_wdata_i;
  logic [NC*BW-1:0] data_be_i;
  logic [NC*IW-1:0] data_ID_i;
  logic [NC*XW-1:0] data_aux_i;
  logic [NC-1:0]   data_gnt_o;
  logic            data_req_o;
  logic [AW-1:0]   data_add_o;
  logic            data_wen_o;
  logic [DW-1:0]   data_wdata_o;
  logic [BW-1:0]   data_be_o;
  logic [IW-1:0]   data_ID_o;
  logic [XW-1:0]   data_aux_o;
  logic            data_gnt_i;
  logic            data_r_valid_i;
  logic [DW-1:0]   data_r_rdata_i;
  logic [NC-1:0]   data_r_valid_o;
  logic [DW-1:0]   data_r_rdata_o;
  logic [CW-1:0]   outst_cnt_o;
  logic            resp_err_o;

  int checks   = 0;
  int failures = 0;

  xbar_bridge_rr_arbiter #(
    .N_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
    .ID_WIDTH(IW), .AUX_WIDTH(XW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
    .data_aux_i(data_aux_i), .data_gnt_o(data_gnt_o), .data_req_o(data_req_o),
    .data_add_o(data_add_o), .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o),
    .data_be_o(data_be_o), .data_ID_o(data_ID_o), .data_aux_o(data_aux_o),
    .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i),
    .data_r_rdata_i(data_r_rdata_i), .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o), .outst_cnt_o(outst_cnt_o), .resp_err_o(resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] exp_add(input int ch);
    return 32'hA000_0000 + 32'(ch);
  endfunction

  function automatic logic [IW-1:0] exp_id(input int ch);
    return 20'h00100 + 20'(ch);
  endfunction

  // Apply one cycle of inputs at the falling edge, then settle before sampling.
  task automatic step(input logic [NC-1:0] req, input logic gnt, input logic rv);
    @(negedge clk);
    data_req_i     = req;
    data_gnt_i     = gnt;
    data_r_valid_i = rv;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    data_req_i = '0; data_gnt_i = 1'b0; data_r_valid_i = 1'b0;
    data_r_rdata_i = '0;
    #12;
    checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", data_req_o); end
    checks++; if (data_gnt_o !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", data_gnt_o); end
    checks++; if (data_r_valid_o !== 4'b0000) begin failures++; $display("FAIL rst_rvalid got=%b exp=0000", data_r_valid_o); end
    checks++; if (resp_err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", resp_err_o); end
    checks++; if (outst_cnt_o !== 3'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", outst_cnt_o); end
    checks++; if (data_add_o !== exp_add(0)) begin failures++; $display("FAIL rst_add got=%h exp=%h", data_add_o, exp_add(0)); end
    checks++; if (data_ID_o !== exp_id(0)) begin failures++; $display("FAIL rst_id got=%h exp=%h", data_ID_o, exp_id(0)); end
    checks++; if (data_wen_o !== 1'b1) begin failures++; $display("FAIL rst_wen got=%b exp=1", data_wen_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // All channels request back to back, and each response arrives one cycle after its grant.
  task automatic test_back_to_back;
    logic [NC-1:0] eg;
    logic [NC-1:0] er;
    for (int k = 0; k < 5; k++) begin
      data_r_rdata_i = 32'hCAFE_0000 + 32'(k);
      step(4'b1111, 1'b1, (k > 0));
      eg = 4'(1 << (k % 4));
      er = (k > 0) ? 4'(1 << ((k - 1) % 4)) : 4'b0000;
      checks++; if (data_gnt_o !== eg) begin failures++; $display("FAIL b2b_gnt k=%0d got=%b exp=%b", k, data_gnt_o, eg); end
      checks++; if (data_add_o !== exp_add(k % 4)) begin failures++; $display("FAIL b2b_add k=%0d got=%h exp=%h", k, data_add_o, exp_add(k % 4)); end
      checks++; if (data_r_valid_o !== er) begin failures++; $display("FAIL b2b_rvalid k=%0d got=%b exp=%b", k, data_r_valid_o, er); end
      checks++; if (outst_cnt_o !== ((k == 0) ? 3'd0 : 3'd1)) begin failures++; $display("FAIL b2b_cnt k=%0d got=%0d", k, outst_cnt_o); end
      checks++; if (data_r_rdata_o !== 32'hCAFE_0000 + 32'(k)) begin failures++; $display("FAIL b2b_rdata k=%0d got=%h", k, data_r_rdata_o); end
    end
    step(4'b0000, 1'b0, 1'b1);
    checks++; if (data_r_valid_o !== 4'b0001) begin failures++; $display("FAIL b2b_last_rvalid got=%b exp=0001", data_r_valid_o); end
    step(4'b0000, 1'b0, 1'b0);
    checks++; if (outst_cnt_o !== 3'd0) begin failures++; $display("FAIL b2b_drain_cnt got=%0d exp=0", outst_cnt_o); end
  endtask

  // rr_ptr is 1 here. A lone ch2 moves it to 3, and ch2 is then picked again after wrapping.
  task automatic test_rr_skip;
    step(4'b0100, 1'b1, 1'b0);
    checks++; if (data_gnt_o !== 4'b0100) begin failures++; $display("FAIL skip_gnt_a got=%b exp=0100", data_gnt_o); end
    step(4'b0100, 1'b1, 1'b1);
    checks++; if (data_gnt_o !== 4'b0100) begin failures++; $display("FAIL skip_gnt_b got=%b exp=0100", data_gnt_o); end
    checks++; if (data_r_valid_o !== 4'b0100) begin failures++; $display("FAIL skip_rv_b got=%b exp=0100", data_r_valid_o); end
    step(4'b1001, 1'b1, 1'b1);
    checks++; if (data_gnt_o !== 4'b1000) begin failures++; $display("FAIL skip_gnt_c got=%b exp=1000", data_gnt_o); end
    checks++; if (data_add_o !== exp_add(3)) begin failures++; $display("FAIL skip_add_c got=%h exp=%h", data_add_o, exp_add(3)); end
    checks++; if (data_r_valid_o !== 4'b0100) begin failures++; $display("FAIL skip_rv_c got=%b exp=0100", data_r_valid_o); end
    step(4'b0001, 1'b1, 1'b1);
    checks++; if (data_gnt_o !== 4'b0001) begin failures++; $display("FAIL skip_gnt_d got=%b exp=0001", data_gnt_o); end
    checks++; if (data_r_valid_o !== 4'b1000) begin failures++; $display("FAIL skip_rv_d got=%b exp=1000", data_r_valid_o); end
    step(4'b0000, 1'b0, 1'b1);
    checks++; if (data_r_valid_o !== 4'b0001) begin failures++; $display("FAIL skip_rv_e got=%b exp=0001", data_r_valid_o); end
    step(4'b0000, 1'b0, 1'b0);
    checks++; if (outst_cnt_o !== 3'd0) begin failures++; $display("FAIL skip_cnt got=%0d exp=0", outst_cnt_o); end
  endtask

  // The target withholds its grant, so nothing is issued and the pointer stays at 0.
  task automatic test_stall;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(4'b0010, 1'b0, 1'b0);
      checks++; if (data_req_o !== 1'b1) begin failures++; $display("FAIL stall_req k=%0d got=%b exp=1", k, data_req_o); end
      checks++; if (data_gnt_o !== 4'b0000) begin failures++; $display("FAIL stall_gnt k=%0d got=%b exp=0000", k, data_gnt_o); end
      checks++; if (outst_cnt_o !== 3'd0) begin failures++; $display("FAIL stall_cnt k=%0d got=%0d exp=0", k, outst_cnt_o); end
      checks++; if (data_add_o !== exp_add(1)) begin failures++; $display("FAIL stall_add k=%0d got=%h exp=%h", k, data_add_o, exp_add(1)); end
    end
    step(4'b0000, 1'b0, 1'b0);
    checks++; if (data_add_o !== exp_add(0)) begin failures++; $display("FAIL stall_ptr got=%h exp=%h", data_add_o, exp_add(0)); end
    checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL stall_idle_req got=%b exp=0", data_req_o); end
  endtask

  // Fill the route queue, then check that a same-cycle pop does not unblock a grant.
  task automatic test_full;
    logic [NC-1:0] drain_exp [4];
    drain_exp[0] = 4'b0010; drain_exp[1] = 4'b0100; drain_exp[2] = 4'b1000; drain_exp[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step(4'b1111, 1'b1, 1'b0);
      checks++; if (data_gnt_o !== 4'(1 << k)) begin failures++; $display("FAIL full_fill_gnt k=%0d got=%b", k, data_gnt_o); end
      checks++; if (outst_cnt_o !== 3'(k)) begin failures++; $display("FAIL full_fill_cnt k=%0d got=%0d exp=%0d", k, outst_cnt_o, k); end
    end
    step(4'b1111, 1'b1, 1'b0);
    checks++; if (outst_cnt_o !== 3'd4) begin failures++; $display("FAIL full_cnt got=%0d exp=4", outst_cnt_o); end
    checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL full_req got=%b exp=0", data_req_o); end
    checks++; if (data_gnt_o !== 4'b0000) begin failures++; $display("FAIL full_gnt got=%b exp=0000", data_gnt_o); end
    step(4'b1111, 1'b1, 1'b1);
    checks++; if (data_r_valid_o !== 4'b0001) begin failures++; $display("FAIL full_pop_rv got=%b exp=0001", data_r_valid_o); end
    checks++; if (data_gnt_o !== 4'b0000) begin failures++; $display("FAIL full_pop_gnt got=%b exp=0000", data_gnt_o); end
    step(4'b1111, 1'b1, 1'b0);
    checks++; if (outst_cnt_o !== 3'd3) begin failures++; $display("FAIL full_after_pop_cnt got=%0d exp=3", outst_cnt_o); end
    checks++; if (data_gnt_o !== 4'b0001) begin failures++; $display("FAIL full_regrant got=%b exp=0001", data_gnt_o); end
    step(4'b0000, 1'b0, 1'b0);
    checks++; if (outst_cnt_o !== 3'd4) begin failures++; $display("FAIL full_refill_cnt got=%0d exp=4", outst_cnt_o); end
    for (int j = 0; j < 4; j++) begin
      step(4'b0000, 1'b0, 1'b1);
      checks++; if (data_r_valid_o !== drain_exp[j]) begin failures++; $display("FAIL full_drain j=%0d got=%b exp=%b", j, data_r_valid_o, drain_exp[j]); end
    end
    step(4'b0000, 1'b0, 1'b0);
    checks++; if (outst_cnt_o !== 3'd0) begin failures++; $display("FAIL full_drain_cnt got=%0d exp=0", outst_cnt_o); end
  endtask

  // A response arriving with nothing outstanding.
  task automatic test_resp_err;
    step(4'b0000, 1'b0, 1'b1);
    checks++; if (resp_err_o !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", resp_err_o); end
    checks++; if (data_r_valid_o !== 4'b0000) begin failures++; $display("FAIL err_rvalid got=%b exp=0000", data_r_valid_o); end
    step(4'b0000, 1'b0, 1'b0);
    checks++; if (resp_err_o !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", resp_err_o); end
    checks++; if (outst_cnt_o !== 3'd0) begin failures++; $display("FAIL err_cnt got=%0d exp=0", outst_cnt_o); end
  endtask

  // Reset asserted mid-cycle with three transactions outstanding.
  task automatic test_async_reset;
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    checks++; if (outst_cnt_o !== 3'd3) begin failures++; $display("FAIL areset_pre_cnt got=%0d exp=3", outst_cnt_o); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (outst_cnt_o !== 3'd0) begin failures++; $display("FAIL areset_cnt got=%0d exp=0", outst_cnt_o); end
    checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL areset_req got=%b exp=0", data_req_o); end
    checks++; if (data_gnt_o !== 4'b0000) begin failures++; $display("FAIL areset_gnt got=%b exp=0000", data_gnt_o); end
    checks++; if (data_add_o !== exp_add(0)) begin failures++; $display("FAIL areset_add got=%h exp=%h", data_add_o, exp_add(0)); end
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 1'b0, 1'b1);
    checks++; if (resp_err_o !== 1'b1) begin failures++; $display("FAIL areset_orphan got=%b exp=1", resp_err_o); end
    step(4'b1111, 1'b1, 1'b0);
    checks++; if (data_gnt_o !== 4'b0001) begin failures++; $display("FAIL areset_first_gnt got=%b exp=0001", data_gnt_o); end
    checks++; if (data_add_o !== exp_add(0)) begin failures++; $display("FAIL areset_first_add got=%h exp=%h", data_add_o, exp_add(0)); end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      data_add_i[c*AW +: AW]   = exp_add(c);
      data_wdata_i[c*DW +: DW] = 32'hD000_0000 + 32'(c);
      data_be_i[c*BW +: BW]    = 4'(1 << c);
      data_ID_i[c*IW +: IW]    = exp_id(c);
      data_aux_i[c*XW +: XW]   = 6'(c + 1);
    end
    data_wen_i = 4'b0101;
    test_reset();
    test_back_to_back();
    test_rr_skip();
    test_stall();
    test_full();
    test_resp_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
